// File: rtl/count_step_ctrl.sv
// count_step_ctrl: 2-FF synchronizer, debouncer and press/auto-repeat FSM
// producing single-cycle step pulses for a downstream counter enable.
module count_step_ctrl #(
  parameter int DB_CYCLES     = 16,
  parameter int HOLD_CYCLES   = 64,
  parameter int REPEAT_CYCLES = 16,
  parameter int TW            = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic step,
  output logic held,
  output logic btn_level
);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;
  localparam logic [TW-1:0] DB_MAX  = TW'(DB_CYCLES - 1);
  localparam logic [TW-1:0] HOLD_MAX = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_MAX  = TW'(REPEAT_CYCLES - 1);
  logic s1, s2;
  logic [TW-1:0] db_cnt, timer;
  state_t state;
  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      btn_level <= 1'b0;
      db_cnt    <= '0;
      timer     <= '0;
      state     <= IDLE;
      step      <= 1'b0;
      held      <= 1'b0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      if (s2 == btn_level) db_cnt <= '0;
      else if (db_cnt == DB_MAX) begin
        btn_level <= s2;
        db_cnt    <= '0;
      end else db_cnt <= db_cnt + 1'b1;
      step <= 1'b0;
      held <= 1'b0;
      // FSM acts on the debounced level as registered before this edge
      case (state)
        IDLE: if (btn_level) begin
          step  <= 1'b1;
          timer <= '0;
          state <= HOLD;
          held  <= 1'b1;
        end
        HOLD: if (!btn_level) state <= IDLE;
        else begin
          held <= 1'b1;
          if (repeat_en && timer == HOLD_MAX) begin
            step  <= 1'b1;
            timer <= '0;
            state <= REPEAT;
          end else if (timer != HOLD_MAX) timer <= timer + 1'b1;
        end
        REPEAT: if (!btn_level) state <= IDLE;
        else begin
          held <= 1'b1;
          if (!repeat_en) begin
            state <= HOLD;
            timer <= '0;
          end else if (timer == REP_MAX) begin
            step  <= 1'b1;
            timer <= '0;
          end else timer <= timer + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_count_step_ctrl.sv
// tb_count_step_ctrl: directed scenario tests for count_step_ctrl
module tb_count_step_ctrl;
  logic clk = 1'b0, reset = 1'b1, btn_raw = 1'b0, repeat_en = 1'b0;
  logic step, held, btn_level;
  int vectors = 0, errors = 0;
  int cyc, held_cnt;
  logic lvl_hi;
  int steps[$];

  count_step_ctrl #(.DB_CYCLES(4), .HOLD_CYCLES(8), .REPEAT_CYCLES(3), .TW(8)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .repeat_en(repeat_en),
    .step(step), .held(held), .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  // cyc counts edges since start(); step times are logged by edge number
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (step) steps.push_back(cyc);
    if (held) held_cnt++;
    if (btn_level) lvl_hi = 1'b1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start();
    cyc = 0;
    held_cnt = 0;
    lvl_hi = 1'b0;
    steps.delete();
  endtask

  task automatic settle();
    btn_raw = 1'b0;
    repeat_en = 1'b0;
    ticks(20);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_raw = 1'b1;
    ticks(3);
    vectors++; if (step !== 1'b0) begin errors++; $display("FAIL reset_step got %b exp 0", step); end
    vectors++; if (held !== 1'b0) begin errors++; $display("FAIL reset_held got %b exp 0", held); end
    vectors++; if (btn_level !== 1'b0) begin errors++; $display("FAIL reset_level got %b exp 0", btn_level); end
    reset = 1'b0;
    start();
    ticks(5);
    vectors++; if (btn_level !== 1'b0) begin errors++; $display("FAIL rel_level_early got %b exp 0", btn_level); end
    tick();
    vectors++; if (btn_level !== 1'b1) begin errors++; $display("FAIL rel_level_edge6 got %b exp 1", btn_level); end
    vectors++; if (step !== 1'b0) begin errors++; $display("FAIL rel_step_edge6 got %b exp 0", step); end
    tick();
    vectors++; if (step !== 1'b1) begin errors++; $display("FAIL rel_step_edge7 got %b exp 1", step); end
    tick();
    vectors++; if (step !== 1'b0) begin errors++; $display("FAIL rel_step_edge8 got %b exp 0", step); end
    vectors++; if (held !== 1'b1) begin errors++; $display("FAIL rel_held_edge8 got %b exp 1", held); end
    settle();
    vectors++; if (held !== 1'b0) begin errors++; $display("FAIL rel_held_idle got %b exp 0", held); end
  endtask

  task automatic test_clean_press();
    start();
    repeat_en = 1'b0;
    btn_raw = 1'b1;
    ticks(40);
    btn_raw = 1'b0;
    ticks(20);
    vectors++; if (steps.size() !== 1) begin errors++; $display("FAIL press_nsteps got %0d exp 1", steps.size()); end
    else begin
      vectors++; if (steps[0] !== 7) begin errors++; $display("FAIL press_step_at got %0d exp 7", steps[0]); end
    end
    vectors++; if (held_cnt !== 40) begin errors++; $display("FAIL press_held_cycles got %0d exp 40", held_cnt); end
    vectors++; if (held !== 1'b0 || btn_level !== 1'b0) begin errors++; $display("FAIL press_end got held=%b level=%b exp 0/0", held, btn_level); end
    settle();
  endtask

  task automatic test_bounce();
    start();
    for (int p = 0; p < 10; p++) begin
      btn_raw = (p % 2 == 0);
      ticks(2);
    end
    vectors++; if (lvl_hi !== 1'b0) begin errors++; $display("FAIL bounce_level got %b exp 0", lvl_hi); end
    btn_raw = 1'b1;
    ticks(10);
    btn_raw = 1'b0;
    ticks(20);
    vectors++; if (steps.size() !== 1) begin errors++; $display("FAIL bounce_nsteps got %0d exp 1", steps.size()); end
    else begin
      vectors++; if (steps[0] !== 27) begin errors++; $display("FAIL bounce_step_at got %0d exp 27", steps[0]); end
    end
    settle();
  endtask

  task automatic test_glitch();
    start();
    btn_raw = 1'b1;
    ticks(3);
    btn_raw = 1'b0;
    ticks(20);
    vectors++; if (lvl_hi !== 1'b0) begin errors++; $display("FAIL glitch_level got %b exp 0", lvl_hi); end
    vectors++; if (steps.size() !== 0) begin errors++; $display("FAIL glitch_nsteps got %0d exp 0", steps.size()); end
  endtask

  task automatic test_auto_repeat();
    int exp_s[9] = '{7, 15, 18, 21, 24, 27, 30, 33, 36};
    start();
    repeat_en = 1'b1;
    btn_raw = 1'b1;
    ticks(30);
    btn_raw = 1'b0;
    ticks(20);
    vectors++; if (steps.size() !== 9) begin errors++; $display("FAIL repeat_nsteps got %0d exp 9", steps.size()); end
    for (int i = 0; i < 9 && i < steps.size(); i++) begin
      vectors++; if (steps[i] !== exp_s[i]) begin errors++; $display("FAIL repeat_step%0d got %0d exp %0d", i, steps[i], exp_s[i]); end
    end
    settle();
  endtask

  task automatic test_release_vs_due();
    start();
    repeat_en = 1'b1;
    btn_raw = 1'b1;
    ticks(32);
    btn_raw = 1'b0;
    ticks(6);
    vectors++; if (held !== 1'b1) begin errors++; $display("FAIL due_held_edge38 got %b exp 1", held); end
    tick();
    vectors++; if (step !== 1'b0) begin errors++; $display("FAIL due_step_edge39 got %b exp 0", step); end
    vectors++; if (held !== 1'b0) begin errors++; $display("FAIL due_held_edge39 got %b exp 0", held); end
    ticks(10);
    vectors++; if (steps.size() !== 9) begin errors++; $display("FAIL due_nsteps got %0d exp 9", steps.size()); end
    else begin
      vectors++; if (steps[8] !== 36) begin errors++; $display("FAIL due_last_step got %0d exp 36", steps[8]); end
    end
    settle();
  endtask

  task automatic test_repeat_toggle();
    int exp_s[6] = '{7, 15, 18, 27, 30, 33};
    start();
    repeat_en = 1'b1;
    btn_raw = 1'b1;
    ticks(18);
    repeat_en = 1'b0;
    tick();
    vectors++; if (held !== 1'b1) begin errors++; $display("FAIL toggle_held got %b exp 1", held); end
    vectors++; if (step !== 1'b0) begin errors++; $display("FAIL toggle_step got %b exp 0", step); end
    repeat_en = 1'b1;
    ticks(9);
    btn_raw = 1'b0;
    ticks(20);
    vectors++; if (steps.size() !== 6) begin errors++; $display("FAIL toggle_nsteps got %0d exp 6", steps.size()); end
    for (int i = 0; i < 6 && i < steps.size(); i++) begin
      vectors++; if (steps[i] !== exp_s[i]) begin errors++; $display("FAIL toggle_step%0d got %0d exp %0d", i, steps[i], exp_s[i]); end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_auto_repeat();
    test_release_vs_due();
    test_repeat_toggle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
